// File: rtl/apb_master_ctrl_p_if.sv
// AHB-side request/response and APB-side bus signals of the AHB-to-APB controller.
// Latency: none; this is only a bundle of wires.
// Backpressure: hreadyout stalls the AHB side and pready stalls the APB side.
interface apb_master_ctrl_p_if #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int NUM_SLV = 3
);
    // AHB side
    logic               valid;
    logic               hwrite;
    logic [ADDR_W-1:0]  haddr;
    logic [DATA_W-1:0]  hwdata;
    logic [NUM_SLV-1:0] tempselx;
    logic               hreadyout;
    logic               hresp;
    logic [DATA_W-1:0]  hrdata;
    // APB side
    logic [DATA_W-1:0]  prdata;
    logic               pready;
    logic               pslverr;
    logic [NUM_SLV-1:0] pselx;
    logic               penable;
    logic               pwrite;
    logic [ADDR_W-1:0]  paddr;
    logic [DATA_W-1:0]  pwdata;

    // Controller view
    modport master (
        input  valid, hwrite, haddr, hwdata, tempselx, prdata, pready, pslverr,
        output pselx, penable, pwrite, paddr, pwdata, hreadyout, hresp, hrdata
    );

    // Environment view (AHB slave front-end plus APB peripherals)
    modport slave (
        output valid, hwrite, haddr, hwdata, tempselx, prdata, pready, pslverr,
        input  pselx, penable, pwrite, paddr, pwdata, hreadyout, hresp, hrdata
    );
endinterface

// File: rtl/apb_master_ctrl_p.sv
// AHB-to-APB3 controller: runs SETUP/ACCESS to one of NUM_SLV peripherals, maps pslverr/timeout to AHB ERROR.
// Latency: read 3 cycles, write 4 cycles at zero wait states; each pready=0 cycle adds one.
// Backpressure: hreadyout=0 from accept until completion; pready=0 holds ACCESS until TIMEOUT aborts it.
module apb_master_ctrl_p #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int NUM_SLV = 3,
    parameter int TIMEOUT = 16
) (
    input  logic               hclk,
    input  logic               hresetn,
    apb_master_ctrl_p_if.master bus
);
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    // Counter value seen in the last ACCESS cycle allowed before the abort
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

    typedef enum logic [2:0] {IDLE, WWAIT, SETUP, ACCESS, ERR1, ERR2} state_t;

    state_t             state_q, state_d;
    logic [NUM_SLV-1:0] sel_q, sel_d;
    logic               wr_q, wr_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [NUM_SLV-1:0] pselx_q, pselx_d;
    logic               penable_q, penable_d;
    logic               pwrite_q, pwrite_d;
    logic [ADDR_W-1:0]  paddr_q, paddr_d;
    logic [DATA_W-1:0]  pwdata_q, pwdata_d;
    logic               hreadyout_q, hreadyout_d;
    logic               hresp_q, hresp_d;
    logic [DATA_W-1:0]  hrdata_q, hrdata_d;

    // Next state and next registered outputs; outputs are decoded from the state being entered
    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        wr_d     = wr_q;
        addr_d   = addr_q;
        cnt_d    = cnt_q;
        paddr_d  = paddr_q;
        pwrite_d = pwrite_q;
        pwdata_d = pwdata_q;
        hrdata_d = hrdata_q;

        case (state_q)
            // ERR2 accepts exactly like IDLE so an error response costs no extra bubble
            IDLE, ERR2: begin
                state_d = IDLE;
                if (bus.valid) begin
                    sel_d  = bus.tempselx;
                    wr_d   = bus.hwrite;
                    addr_d = bus.haddr;
                    if (!$onehot(bus.tempselx)) begin
                        state_d = ERR1;
                    end else if (bus.hwrite) begin
                        state_d = WWAIT;
                    end else begin
                        state_d = SETUP;
                    end
                end
            end
            WWAIT: begin
                pwdata_d = bus.hwdata;
                state_d  = SETUP;
            end
            SETUP: begin
                state_d = ACCESS;
            end
            ACCESS: begin
                if (bus.pready) begin
                    if (bus.pslverr) begin
                        state_d = ERR1;
                    end else begin
                        state_d = IDLE;
                        if (!wr_q) begin
                            hrdata_d = bus.prdata;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if ((TIMEOUT != 0) && (cnt_q == TO_LAST)) begin
                        state_d = ERR1;
                    end
                end
            end
            ERR1: begin
                state_d = ERR2;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // APB address/direction only move when a new access begins; they hold otherwise
        if (state_d == SETUP) begin
            paddr_d  = addr_d;
            pwrite_d = wr_d;
            cnt_d    = '0;
        end

        pselx_d     = ((state_d == SETUP) || (state_d == ACCESS)) ? sel_d : '0;
        penable_d   = (state_d == ACCESS);
        hreadyout_d = (state_d == IDLE) || (state_d == ERR2);
        hresp_d     = (state_d == ERR1) || (state_d == ERR2);
    end

    // State, latches and output registers with synchronous reset that also drops any APB access
    always_ff @(posedge hclk) begin
        if (!hresetn) begin
            state_q     <= IDLE;
            sel_q       <= '0;
            wr_q        <= 1'b0;
            addr_q      <= '0;
            cnt_q       <= '0;
            pselx_q     <= '0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            hreadyout_q <= 1'b1;
            hresp_q     <= 1'b0;
            hrdata_q    <= '0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            wr_q        <= wr_d;
            addr_q      <= addr_d;
            cnt_q       <= cnt_d;
            pselx_q     <= pselx_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            hreadyout_q <= hreadyout_d;
            hresp_q     <= hresp_d;
            hrdata_q    <= hrdata_d;
        end
    end

    assign bus.pselx     = pselx_q;
    assign bus.penable   = penable_q;
    assign bus.pwrite    = pwrite_q;
    assign bus.paddr     = paddr_q;
    assign bus.pwdata    = pwdata_q;
    assign bus.hreadyout = hreadyout_q;
    assign bus.hresp     = hresp_q;
    assign bus.hrdata    = hrdata_q;
endmodule

// File: tb/tb_apb_master_ctrl_p.sv
// Bench for apb_master_ctrl_p: directed plan cases plus random transfers against a transaction-level model.
// Latency: model derives every cycle's expected outputs from the transfer's type, wait count and outcome.
// Backpressure: pready wait states and timeout aborts are generated per transfer.
module tb_apb_master_ctrl_p;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int NS = 3;
    localparam int TO = 4;

    logic hclk    = 1'b0;
    logic hresetn = 1'b0;
    always #5 hclk = ~hclk;

    apb_master_ctrl_p_if #(.ADDR_W(AW), .DATA_W(DW), .NUM_SLV(NS)) bus ();
    apb_master_ctrl_p_if #(.ADDR_W(AW), .DATA_W(DW), .NUM_SLV(NS)) bus0 ();

    apb_master_ctrl_p #(.ADDR_W(AW), .DATA_W(DW), .NUM_SLV(NS), .TIMEOUT(TO)) u_dut (
        .hclk    (hclk),
        .hresetn (hresetn),
        .bus     (bus.master)
    );

    apb_master_ctrl_p #(.ADDR_W(AW), .DATA_W(DW), .NUM_SLV(NS), .TIMEOUT(0)) u_dut_noto (
        .hclk    (hclk),
        .hresetn (hresetn),
        .bus     (bus0.master)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // Transaction-level model state
    logic [DW-1:0] m_hrdata;
    logic          m_hresp;
    logic [DW-1:0] m_pwdata;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge hclk);
        #1;
    endtask

    // AHB inputs carry random garbage whenever the controller must ignore them
    task automatic drive_junk();
        bus.valid    = 1'($urandom);
        bus.hwrite   = 1'($urandom);
        bus.haddr    = $urandom;
        bus.tempselx = 3'($urandom);
        bus.hwdata   = $urandom;
    endtask

    task automatic ready_checks(input string tag);
        chk({tag, ".hreadyout"}, bus.hreadyout, 1'b1);
        chk({tag, ".hresp"},     bus.hresp,     m_hresp);
        chk({tag, ".pselx"},     bus.pselx,     3'b000);
        chk({tag, ".penable"},   bus.penable,   1'b0);
        chk({tag, ".hrdata"},    bus.hrdata,    m_hrdata);
    endtask

    task automatic idle_cycle();
        drive_junk();
        bus.valid = 1'b0;
        @(negedge hclk);
        ready_checks("idle");
        tick();
        m_hresp = 1'b0;
    endtask

    // One transfer: starts in a cycle with hreadyout=1, returns in the next such cycle
    task automatic xfer(input logic wr, input logic [AW-1:0] addr, input logic [NS-1:0] sel,
                        input logic [DW-1:0] wdata, input logic [DW-1:0] rdata,
                        input int waits, input logic err);
        int   acc;
        logic timed;
        logic last;
        bus.valid    = 1'b1;
        bus.hwrite   = wr;
        bus.haddr    = addr;
        bus.tempselx = sel;
        bus.pready   = 1'($urandom);
        bus.pslverr  = 1'($urandom);
        @(negedge hclk);
        ready_checks("accept");
        tick();

        if ($countones(sel) != 1) begin
            drive_junk();
            @(negedge hclk);
            chk("badsel.err1.hreadyout", bus.hreadyout, 1'b0);
            chk("badsel.err1.hresp",     bus.hresp,     1'b1);
            chk("badsel.err1.pselx",     bus.pselx,     3'b000);
            chk("badsel.err1.penable",   bus.penable,   1'b0);
            tick();
            m_hresp = 1'b1;
            return;
        end

        if (wr) begin
            drive_junk();
            bus.hwdata = wdata;
            @(negedge hclk);
            chk("wwait.hreadyout", bus.hreadyout, 1'b0);
            chk("wwait.hresp",     bus.hresp,     1'b0);
            chk("wwait.pselx",     bus.pselx,     3'b000);
            tick();
            m_pwdata = wdata;
        end

        drive_junk();
        bus.pready = 1'($urandom);
        bus.prdata = $urandom;
        @(negedge hclk);
        chk("setup.pselx",     bus.pselx,     sel);
        chk("setup.penable",   bus.penable,   1'b0);
        chk("setup.paddr",     bus.paddr,     addr);
        chk("setup.pwrite",    bus.pwrite,    wr);
        chk("setup.hreadyout", bus.hreadyout, 1'b0);
        if (wr) chk("setup.pwdata", bus.pwdata, m_pwdata);
        tick();

        timed = (TO != 0) && (waits >= TO);
        acc   = timed ? TO : waits + 1;
        for (int i = 0; i < acc; i++) begin
            drive_junk();
            last        = (i == acc - 1) && !timed;
            bus.pready  = last;
            bus.pslverr = last ? err : 1'($urandom);
            bus.prdata  = last ? rdata : $urandom;
            @(negedge hclk);
            chk("access.pselx",     bus.pselx,     sel);
            chk("access.penable",   bus.penable,   1'b1);
            chk("access.paddr",     bus.paddr,     addr);
            chk("access.pwrite",    bus.pwrite,    wr);
            chk("access.hreadyout", bus.hreadyout, 1'b0);
            chk("access.hresp",     bus.hresp,     1'b0);
            if (wr) chk("access.pwdata", bus.pwdata, m_pwdata);
            tick();
        end

        if (timed || err) begin
            drive_junk();
            @(negedge hclk);
            chk("err1.hreadyout", bus.hreadyout, 1'b0);
            chk("err1.hresp",     bus.hresp,     1'b1);
            chk("err1.pselx",     bus.pselx,     3'b000);
            chk("err1.penable",   bus.penable,   1'b0);
            chk("err1.hrdata",    bus.hrdata,    m_hrdata);
            tick();
            m_hresp = 1'b1;
        end else begin
            m_hresp = 1'b0;
            if (!wr) m_hrdata = rdata;
        end
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, ".pselx"},     bus.pselx,     3'b000);
        chk({tag, ".penable"},   bus.penable,   1'b0);
        chk({tag, ".pwrite"},    bus.pwrite,    1'b0);
        chk({tag, ".paddr"},     bus.paddr,     32'h0);
        chk({tag, ".pwdata"},    bus.pwdata,    32'h0);
        chk({tag, ".hrdata"},    bus.hrdata,    32'h0);
        chk({tag, ".hresp"},     bus.hresp,     1'b0);
        chk({tag, ".hreadyout"}, bus.hreadyout, 1'b1);
    endtask

    initial begin
        logic [NS-1:0] sel;
        logic [NS-1:0] hot [3];
        hot[0] = 3'b001;
        hot[1] = 3'b010;
        hot[2] = 3'b100;

        bus.valid = 1'b0;  bus.hwrite = 1'b0;  bus.haddr = '0;  bus.hwdata = '0;
        bus.tempselx = '0; bus.prdata = '0;    bus.pready = 1'b0; bus.pslverr = 1'b0;
        bus0.valid = 1'b0; bus0.hwrite = 1'b0; bus0.haddr = '0; bus0.hwdata = '0;
        bus0.tempselx = '0; bus0.prdata = '0;  bus0.pready = 1'b0; bus0.pslverr = 1'b0;
        m_hrdata = '0;
        m_hresp  = 1'b0;
        m_pwdata = '0;

        tick();
        tick();
        @(negedge hclk);
        reset_checks("reset");
        hresetn = 1'b1;
        tick();

        // Directed cases from the plan
        xfer(1'b0, 32'h8000_0010, 3'b010, 32'h0, 32'hDEAD_BEEF, 0, 1'b0);
        xfer(1'b1, 32'h8400_0004, 3'b100, 32'h1234_5678, 32'h0, 3, 1'b0);
        xfer(1'b0, 32'h8000_0020, 3'b001, 32'h0, 32'hBAD0_BAD0, 1, 1'b1);
        idle_cycle();
        xfer(1'b0, 32'h8000_0030, 3'b010, 32'h0, 32'h0, 20, 1'b0);
        idle_cycle();
        xfer(1'b1, 32'h8000_0040, 3'b000, 32'h5555_5555, 32'h0, 0, 1'b0);
        idle_cycle();
        xfer(1'b0, 32'h8000_0050, 3'b011, 32'h0, 32'h0, 0, 1'b0);
        idle_cycle();
        // Back-to-back read then write, no idle bubble between them
        xfer(1'b0, 32'h8000_0060, 3'b100, 32'h0, 32'hCAFE_F00D, 0, 1'b0);
        xfer(1'b1, 32'h8000_0064, 3'b001, 32'hA5A5_0F0F, 32'h0, 0, 1'b0);
        idle_cycle();

        // Random transfers, error and timeout outcomes included
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 2) == 0) idle_cycle();
            sel = ($urandom_range(0, 6) != 0) ? hot[$urandom_range(0, 2)] : 3'($urandom);
            xfer(1'($urandom), $urandom, sel, $urandom, $urandom,
                 $urandom_range(0, 6), ($urandom_range(0, 5) == 0));
        end
        idle_cycle();

        // Reset asserted while a write sits in ACCESS
        bus.valid = 1'b1; bus.hwrite = 1'b1; bus.haddr = 32'h8000_0070; bus.tempselx = 3'b100;
        tick();
        bus.valid = 1'b0; bus.hwdata = 32'h7777_8888;
        tick();
        tick();
        bus.pready = 1'b0;
        @(negedge hclk);
        chk("rst.pre.penable", bus.penable, 1'b1);
        hresetn = 1'b0;
        #1;
        tick();
        @(negedge hclk);
        reset_checks("rst_mid");
        hresetn  = 1'b1;
        m_hrdata = '0;
        m_hresp  = 1'b0;
        tick();
        xfer(1'b0, 32'h8000_0080, 3'b001, 32'h0, 32'h0BAD_F00D, 0, 1'b0);
        idle_cycle();

        // TIMEOUT=0 instance waits indefinitely on a hung slave
        bus0.valid = 1'b1; bus0.hwrite = 1'b0; bus0.haddr = 32'h8000_0090; bus0.tempselx = 3'b001;
        tick();
        bus0.valid = 1'b0;
        tick();
        for (int i = 0; i < 100; i++) begin
            bus0.pready = 1'b0;
            @(negedge hclk);
            chk("noto.hang", {bus0.penable, bus0.hreadyout, bus0.hresp}, 3'b100);
            tick();
        end
        bus0.pready = 1'b1; bus0.pslverr = 1'b0; bus0.prdata = 32'hAA55_AA55;
        tick();
        bus0.pready = 1'b0;
        @(negedge hclk);
        chk("noto.done", {bus0.penable, bus0.hreadyout, bus0.hresp}, 3'b010);
        chk("noto.hrdata", bus0.hrdata, 32'hAA55_AA55);

        $display("[TB] %0d tests run, %0d failed", n_chk, n_fail);
        $finish;
    end
endmodule
